// File: rtl/alu_ctrl_exec_if.sv
// alu_ctrl_exec_if: operand/decode request and registered result handshake bundle for alu_ctrl_exec
// Ports: master drives in_valid, aluop, funct3, funct7, op_a, op_b, out_ready;
//   slave drives in_ready, out_valid, result, opera, zero, illegal.
interface alu_ctrl_exec_if #(parameter int XLEN = 32);
  logic in_valid;
  logic in_ready;
  logic [1:0] aluop;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] result;
  logic [3:0] opera;
  logic zero;
  logic illegal;
  modport master(output in_valid, aluop, funct3, funct7, op_a, op_b, out_ready,
                 input in_ready, out_valid, result, opera, zero, illegal);
  modport slave(input in_valid, aluop, funct3, funct7, op_a, op_b, out_ready,
                output in_ready, out_valid, result, opera, zero, illegal);
endinterface

// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: ALU control decode plus registered execute stage with valid/ready handshakes
// Ports: clk; rst_n (async, active-low); bus (alu_ctrl_exec_if.slave) carrying in_valid/in_ready,
//   aluop, funct3, funct7, op_a, op_b in and out_valid/out_ready, result, opera, zero, illegal out.
// Macro ALU_MULDIV_EN adds an iterative XLEN-cycle shift-add MUL; without it funct7=01 R-type is illegal.
module alu_ctrl_exec #(
  parameter int XLEN = 32,
  parameter bit LEGACY_NOR = 1'b1
) (
  input logic clk,
  input logic rst_n,
  alu_ctrl_exec_if.slave bus
);
  localparam int SW = $clog2(XLEN);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000, OP_MUL = 4'b1001, OP_NOR = 4'b1100, OP_SRA = 4'b1101;
`ifdef ALU_MULDIV_EN
  localparam bit MUL_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;
`else
  localparam bit MUL_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif
  state_t state, state_nx;
  logic [3:0] op, opera_q;
  logic bad, rtype, fire, zero_q, illegal_q;
  logic [XLEN-1:0] a, b, res, result_q;
  logic [SW-1:0] sh;
  logic [6:0] f7;
  assign a = bus.op_a;
  assign b = bus.op_b;
  assign sh = b[SW-1:0];
  assign f7 = bus.funct7;
  assign rtype = bus.aluop[1];
  // Load/store (01) always adds, branch (11) always subtracts; only I/R-type look at funct3/funct7.
  always_comb begin
    op = OP_ADD;
    bad = 1'b0;
    if (bus.aluop == 2'b11) op = OP_SUB;
    else if (!bus.aluop[0]) begin
      case (bus.funct3)
        3'b111: op = OP_AND;
        3'b110: op = OP_OR;
        3'b100: op = LEGACY_NOR ? OP_NOR : OP_XOR;
        3'b010: op = OP_SLT;
        3'b011: op = OP_SLTU;
        3'b001: op = OP_SLL;
        3'b101: op = f7[5] ? OP_SRA : OP_SRL;
        default: op = !rtype ? OP_ADD : f7[5] ? OP_SUB : f7[0] ? OP_MUL : OP_ADD;
      endcase
      bad = bus.funct3 == 3'b001 ? f7 != 7'h00 :
            bus.funct3 == 3'b101 ? (f7 & ~7'h20) != 7'h00 :
            bus.funct3 == 3'b000 ? rtype && !(f7 == 7'h00 || f7 == 7'h20 || (MUL_EN && f7 == 7'h01)) :
            rtype && f7 != 7'h00;
      if (bad) op = OP_ADD;
    end
  end
  always_comb begin
    res = '0;
    if (!bad)
      case (op)
        OP_AND: res = a & b;
        OP_OR: res = a | b;
        OP_ADD: res = a + b;
        OP_XOR: res = a ^ b;
        OP_SLL: res = a << sh;
        OP_SRL: res = a >> sh;
        OP_SUB: res = a - b;
        OP_SLT: res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
        OP_NOR: res = ~(a | b);
        OP_SRA: res = $signed(a) >>> sh;
        default: res = '0;
      endcase
  end
  assign bus.out_valid = state == HOLD;
  assign bus.in_ready = state == IDLE || (state == HOLD && bus.out_ready);
  assign fire = bus.in_valid && bus.in_ready;
  assign bus.result = result_q;
  assign bus.opera = opera_q;
  assign bus.zero = zero_q;
  assign bus.illegal = illegal_q;
`ifdef ALU_MULDIV_EN
  localparam logic [SW:0] LAST = (SW+1)'(XLEN-1);
  logic [XLEN-1:0] acc, mcand, mplier, acc_nx;
  logic [SW:0] cnt;
  logic done;
  // One multiplier bit per BUSY cycle; acc_nx on the last count is the final product.
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  assign done = state == BUSY && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else if (fire) begin
      acc <= '0;
      mcand <= a;
      mplier <= b;
      cnt <= '0;
    end else if (state == BUSY) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + (SW+1)'(1);
    end
`endif
  always_comb begin
    state_nx = state;
    if (fire) state_nx = HOLD;
    else if (state == HOLD && bus.out_ready) state_nx = IDLE;
`ifdef ALU_MULDIV_EN
    if (fire && op == OP_MUL) state_nx = BUSY;
    if (done) state_nx = HOLD;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      result_q <= '0;
      opera_q <= '0;
      zero_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (fire) begin
        result_q <= res;
        opera_q <= op;
        zero_q <= res == '0;
        illegal_q <= bad;
      end
`ifdef ALU_MULDIV_EN
      if (done) begin
        result_q <= acc_nx;
        zero_q <= acc_nx == '0;
      end
`endif
    end
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb_alu_ctrl_exec: directed and randomized checks of alu_ctrl_exec against a behavioural model
module tb_alu_ctrl_exec;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  alu_ctrl_exec_if #(.XLEN(XLEN)) bus();
  alu_ctrl_exec_if #(.XLEN(XLEN)) bx();
  alu_ctrl_exec #(.XLEN(XLEN), .LEGACY_NOR(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_ctrl_exec #(.XLEN(XLEN), .LEGACY_NOR(1'b0)) dut_x (.clk(clk), .rst_n(rst_n), .bus(bx));
  assign bx.in_valid = bus.in_valid;
  assign bx.aluop = bus.aluop;
  assign bx.funct3 = bus.funct3;
  assign bx.funct7 = bus.funct7;
  assign bx.op_a = bus.op_a;
  assign bx.op_b = bus.op_b;
  assign bx.out_ready = bus.out_ready;
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] res;
    logic [3:0] op;
    logic ill;
    logic mul;
  } exp_t;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, input bit legacy);
    exp_t e;
    longint unsigned ua, ub, sx;
    int s;
    bit rt;
    ua = a;
    ub = b;
    s = int'(b[4:0]);
    rt = ao == 2'b10;
    sx = a[31] ? (ua | 64'hFFFF_FFFF_0000_0000) : ua;
    e.res = 32'(ua + ub);
    e.op = 4'd2;
    e.ill = 1'b0;
    e.mul = 1'b0;
    if (ao == 2'b11) begin
      e.op = 4'd6;
      e.res = 32'(ua + (64'h1_0000_0000 - ub));
    end else if (ao != 2'b01) begin
      case (f3)
        3'd0:
          if (rt && f7 == 7'h20) begin
            e.op = 4'd6;
            e.res = 32'(ua + (64'h1_0000_0000 - ub));
          end else if (rt && f7 == 7'h01) begin
`ifdef ALU_MULDIV_EN
            e.op = 4'd9;
            e.mul = 1'b1;
            e.res = 32'(ua * ub);
`else
            e.ill = 1'b1;
`endif
          end else if (rt && f7 != 7'h00) e.ill = 1'b1;
        3'd1: begin e.op = 4'd4; e.res = 32'(ua * (64'd1 << s)); e.ill = f7 != 7'h00; end
        3'd2: begin e.op = 4'd7; e.res = {31'd0, $signed(a) < $signed(b)}; end
        3'd3: begin e.op = 4'd8; e.res = {31'd0, ua < ub}; end
        3'd4: begin e.op = legacy ? 4'd12 : 4'd3; e.res = legacy ? ~(a | b) : a ^ b; end
        3'd5: begin
          e.op = f7 == 7'h20 ? 4'd13 : 4'd5;
          e.res = 32'((f7 == 7'h20 ? sx : ua) >> s);
          e.ill = f7 != 7'h00 && f7 != 7'h20;
        end
        3'd6: begin e.op = 4'd1; e.res = a | b; end
        default: begin e.op = 4'd0; e.res = a & b; end
      endcase
      if (rt && f3 != 3'd0 && f3 != 3'd1 && f3 != 3'd5 && f7 != 7'h00) e.ill = 1'b1;
      if (e.ill) begin
        e.op = 4'd2;
        e.res = '0;
        e.mul = 1'b0;
      end
    end
    return e;
  endfunction
  exp_t nd, ndx, md, mdx;
  bit mv;
  int mbusy;
  always_comb begin
    nd = model(bus.aluop, bus.funct3, bus.funct7, bus.op_a, bus.op_b, 1'b1);
    ndx = model(bus.aluop, bus.funct3, bus.funct7, bus.op_a, bus.op_b, 1'b0);
  end
  // Transaction-level model: one pending result, accepted when the consumer is free or draining.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mv <= 1'b0;
      mbusy <= 0;
    end else if (mbusy != 0) begin
      mbusy <= mbusy - 1;
      mv <= mbusy == 1;
    end else if (bus.in_valid && (!mv || bus.out_ready)) begin
      md <= nd;
      mdx <= ndx;
      mv <= !nd.mul;
      mbusy <= nd.mul ? XLEN : 0;
    end else if (mv && bus.out_ready) mv <= 1'b0;
  always @(negedge clk)
    if (rst_n) begin
      chk("in_ready", bus.in_ready, mbusy == 0 && (!mv || bus.out_ready));
      chk("out_valid", bus.out_valid, mv);
      if (mv) begin
        chk("result", bus.result, md.res);
        chk("opera", bus.opera, md.op);
        chk("zero", bus.zero, md.res == 0);
        chk("illegal", bus.illegal, md.ill);
        chk("xor_build_result", bx.result, mdx.res);
      end
    end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic [1:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    bus.aluop = ao;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.op_a = a;
    bus.op_b = b;
  endtask
  task automatic do_op(input logic [1:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic [3:0] eo, input logic ez, input logic ei, input int elat, input string nm);
    bit took;
    int n;
    drive(ao, f3, f7, a, b);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    took = 1'b0;
    n = 0;
    while (!took && n < 50) begin
      @(negedge clk);
      took = bus.in_ready;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    chk({nm, "_xfer"}, took, 1);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_opera"}, bus.opera, eo);
    chk({nm, "_zero"}, bus.zero, ez);
    chk({nm, "_illegal"}, bus.illegal, ei);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_t p;
    bit seen;
    int f;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, 3'd0, 7'h00, 32'd0, 32'd0);
    p = model(2'b10, 3'd0, 7'h00, 32'd5, 32'd7, 1'b1);
    chk("pin_add", p.res, 32'd12);
    p = model(2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 1'b1);
    chk("pin_sub", p.res, 32'hFFFF_FFFE);
    p = model(2'b10, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 1'b1);
    chk("pin_sra", p.res, 32'hF800_0000);
    p = model(2'b00, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 1'b1);
    chk("pin_srl", p.res, 32'h0800_0000);
    p = model(2'b10, 3'd4, 7'h00, 32'h0F0F_0F0F, 32'd0, 1'b0);
    chk("pin_xor", p.res, 32'h0F0F_0F0F);
    p = model(2'b10, 3'd5, 7'h7F, 32'h8000_0000, 32'd4, 1'b1);
    chk("pin_shift_illegal", {p.ill, p.op}, 5'h12);
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_opera", bus.opera, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    step();
    do_op(2'b10, 3'd0, 7'h00, 32'd5, 32'd7, 32'd12, 4'd2, 1'b0, 1'b0, 1, "add");
    do_op(2'b10, 3'd0, 7'h20, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'd6, 1'b0, 1'b0, 1, "sub");
    do_op(2'b11, 3'd3, 7'h55, 32'd9, 32'd9, 32'd0, 4'd6, 1'b1, 1'b0, 1, "branch_eq");
    do_op(2'b01, 3'd7, 7'h7F, 32'd100, 32'd24, 32'd124, 4'd2, 1'b0, 1'b0, 1, "ldst");
    do_op(2'b10, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'hF800_0000, 4'd13, 1'b0, 1'b0, 1, "sra");
    do_op(2'b10, 3'd5, 7'h00, 32'h8000_0000, 32'd4, 32'h0800_0000, 4'd5, 1'b0, 1'b0, 1, "srl");
    do_op(2'b10, 3'd5, 7'h7F, 32'h8000_0000, 32'd4, 32'd0, 4'd2, 1'b1, 1'b1, 1, "shift_bad_f7");
    do_op(2'b10, 3'd4, 7'h00, 32'h0F0F_0F0F, 32'd0, 32'hF0F0_F0F0, 4'd12, 1'b0, 1'b0, 1, "nor");
    chk("xor_build_lit", bx.result, 32'h0F0F_0F0F);
    chk("xor_build_opera", bx.opera, 4'd3);
    do_op(2'b00, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'd7, 1'b0, 1'b0, 1, "slt");
    do_op(2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'd8, 1'b1, 1'b0, 1, "sltu");
`ifdef ALU_MULDIV_EN
    do_op(2'b10, 3'd0, 7'h01, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 4'd9, 1'b0, 1'b0, 33, "mul");
`else
    do_op(2'b10, 3'd0, 7'h01, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 4'd2, 1'b1, 1'b1, 1, "mul_disabled");
`endif
    step();
    bus.out_ready = 1'b0;
    drive(2'b10, 3'd0, 7'h00, 32'd100, 32'd1);
    bus.in_valid = 1'b1;
    step();
    drive(2'b10, 3'd0, 7'h00, 32'd200, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_result", bus.result, 32'd101);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 3'd0, 7'h00, 32'd1000 + 32'(i), 32'd1);
      step();
      chk("b2b_valid", bus.out_valid, 1);
      chk("b2b_result", bus.result, 32'd1001 + 32'(i));
    end
    bus.in_valid = 1'b0;
    step();
`ifdef ALU_MULDIV_EN
    drive(2'b10, 3'd0, 7'h01, 32'd3, 32'd5);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= bus.out_valid;
    end
    chk("busy_reset_no_valid", seen, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.out_ready = $urandom_range(0, 9) < 7;
      bus.aluop = 2'($urandom);
      bus.funct3 = 3'($urandom);
      f = $urandom_range(0, 3);
      bus.funct7 = f == 0 ? 7'h00 : f == 1 ? 7'h20 : f == 2 ? 7'h01 : 7'($urandom);
      bus.op_a = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : $urandom;
      bus.op_b = $urandom_range(0, 3) == 0 ? bus.op_a : $urandom;
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_result", bus.result, 0);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 1);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
